// File: rtl/defect_seq_ctrl.sv
// Session controller for the defect detector: arms it, confirms stable bounding boxes over
// consecutive frames and hands one report downstream. Define DEFECT_SEQ_TIMEOUT_EN for the idle-frame session timeout.
module defect_seq_ctrl #(
    parameter int COORD_WID      = 11,
    parameter int CONFIRM_FRAMES = 3,
    parameter int TOL            = 4,
    parameter int TIMEOUT_FRAMES = 15
) (
    input  logic                 pixclk_in,
    input  logic                 rstn_out,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic                 frame_vs,
    input  logic                 defect_valid,
    input  logic [COORD_WID-1:0] bb_xmin,
    input  logic [COORD_WID-1:0] bb_xmax,
    input  logic [COORD_WID-1:0] bb_ymin,
    input  logic [COORD_WID-1:0] bb_ymax,
    input  logic                 rpt_ready,
    output logic                 rpt_valid,
    output logic [COORD_WID-1:0] rpt_xmin,
    output logic [COORD_WID-1:0] rpt_xmax,
    output logic [COORD_WID-1:0] rpt_ymin,
    output logic [COORD_WID-1:0] rpt_ymax,
    output logic [15:0]          rpt_frame_no,
    output logic                 det_en,
    output logic [2:0]           ctrl_state,
    output logic                 sess_timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        REPORT  = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    if (CONFIRM_FRAMES < 1 || CONFIRM_FRAMES > 15) begin : g_bad_confirm
        $error("CONFIRM_FRAMES out of range 1..15");
    end
    if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 255) begin : g_bad_timeout
        $error("TIMEOUT_FRAMES out of range 1..255");
    end

    state_t               state;
    logic                 vs_d;
    logic                 fedge;
    logic [15:0]          frame_no;
    logic [15:0]          frame_inc;
    logic [3:0]           match_cnt;
    logic [3:0]           match_nxt;
    logic                 box_match;
    logic                 confirm;
    logic [COORD_WID-1:0] cand_xmin;
    logic [COORD_WID-1:0] cand_xmax;
    logic [COORD_WID-1:0] cand_ymin;
    logic [COORD_WID-1:0] cand_ymax;
`ifdef DEFECT_SEQ_TIMEOUT_EN
    logic [7:0]           idle_frames;
    logic [7:0]           idle_inc;
    assign idle_inc = idle_frames + 8'd1;
`else
    assign sess_timeout = 1'b0;
`endif

    // Magnitude is taken one bit wider than the coordinates so the difference never overflows.
    function automatic logic within_tol(input logic [COORD_WID-1:0] a,
                                        input logic [COORD_WID-1:0] b);
        logic signed [COORD_WID:0] diff;
        logic signed [COORD_WID:0] mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[COORD_WID] ? -diff : diff;
        return (int'(mag) <= TOL);
    endfunction

    assign fedge      = frame_vs & ~vs_d;
    assign frame_inc  = frame_no + 16'd1;
    assign ctrl_state = state;
    assign box_match  = within_tol(bb_xmin, cand_xmin) & within_tol(bb_xmax, cand_xmax) &
                        within_tol(bb_ymin, cand_ymin) & within_tol(bb_ymax, cand_ymax);

    always_comb begin
        match_nxt = 4'd0;
        if (defect_valid && box_match)
            match_nxt = match_cnt + 4'd1;
        else if (defect_valid)
            match_nxt = 4'd1;
    end

    assign confirm = (match_nxt == 4'(CONFIRM_FRAMES));

    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            state        <= IDLE;
            vs_d         <= 1'b0;
            det_en       <= 1'b0;
            frame_no     <= 16'd0;
            match_cnt    <= 4'd0;
            cand_xmin    <= '0;
            cand_xmax    <= '0;
            cand_ymin    <= '0;
            cand_ymax    <= '0;
            rpt_valid    <= 1'b0;
            rpt_xmin     <= '0;
            rpt_xmax     <= '0;
            rpt_ymin     <= '0;
            rpt_ymax     <= '0;
            rpt_frame_no <= 16'd0;
`ifdef DEFECT_SEQ_TIMEOUT_EN
            idle_frames  <= 8'd0;
            sess_timeout <= 1'b0;
`endif
        end else begin
            vs_d <= frame_vs;
`ifdef DEFECT_SEQ_TIMEOUT_EN
            sess_timeout <= 1'b0;
`endif
            // Stop overrides everything, including a coincident frame edge.
            if (cmd_stop) begin
                state     <= IDLE;
                det_en    <= 1'b0;
                rpt_valid <= 1'b0;
                match_cnt <= 4'd0;
                frame_no  <= 16'd0;
`ifdef DEFECT_SEQ_TIMEOUT_EN
                idle_frames <= 8'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_start) begin
                            state     <= ARM;
                            det_en    <= 1'b1;
                            frame_no  <= 16'd0;
                            match_cnt <= 4'd0;
                        end
                    end
                    ARM: begin
                        if (fedge) begin
                            state     <= MEASURE;
                            match_cnt <= 4'd0;
                            cand_xmin <= '0;
                            cand_xmax <= '0;
                            cand_ymin <= '0;
                            cand_ymax <= '0;
`ifdef DEFECT_SEQ_TIMEOUT_EN
                            idle_frames <= 8'd0;
`endif
                        end
                    end
                    MEASURE: begin
                        if (fedge) begin
                            frame_no  <= frame_inc;
                            match_cnt <= match_nxt;
                            if (defect_valid && !box_match) begin
                                cand_xmin <= bb_xmin;
                                cand_xmax <= bb_xmax;
                                cand_ymin <= bb_ymin;
                                cand_ymax <= bb_ymax;
                            end
                            if (confirm) begin
                                state        <= REPORT;
                                rpt_valid    <= 1'b1;
                                rpt_xmin     <= bb_xmin;
                                rpt_xmax     <= bb_xmax;
                                rpt_ymin     <= bb_ymin;
                                rpt_ymax     <= bb_ymax;
                                rpt_frame_no <= frame_inc;
                            end
`ifdef DEFECT_SEQ_TIMEOUT_EN
                            if (defect_valid) begin
                                idle_frames <= 8'd0;
                            end else if (idle_inc == 8'(TIMEOUT_FRAMES)) begin
                                state        <= IDLE;
                                det_en       <= 1'b0;
                                sess_timeout <= 1'b1;
                                match_cnt    <= 4'd0;
                                idle_frames  <= 8'd0;
                            end else begin
                                idle_frames <= idle_inc;
                            end
`endif
                        end
                    end
                    REPORT: begin
                        if (fedge)
                            frame_no <= frame_inc;
                        if (rpt_ready) begin
                            state     <= HOLDOFF;
                            rpt_valid <= 1'b0;
                        end
                    end
                    HOLDOFF: begin
                        // Wait for the defect to disappear so each occurrence reports once.
                        if (fedge) begin
                            frame_no <= frame_inc;
                            if (!defect_valid) begin
                                state     <= MEASURE;
                                match_cnt <= 4'd0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        det_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_defect_seq_ctrl.sv
// Self-checking bench for defect_seq_ctrl: table vectors, directed corner sequences and
// randomized traffic compared against a frame-level behavioural model.
module tb_defect_seq_ctrl;

    localparam int CW   = 11;
    localparam int CONF = 3;
    localparam int TOLP = 4;
    localparam int TMO  = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_start = 1'b0, cmd_stop = 1'b0, frame_vs = 1'b0, defect_valid = 1'b0;
    logic [CW-1:0] bb_xmin = '0, bb_xmax = '0, bb_ymin = '0, bb_ymax = '0;
    logic          rpt_ready = 1'b0;
    logic          rpt_valid, det_en, sess_timeout;
    logic [CW-1:0] rpt_xmin, rpt_xmax, rpt_ymin, rpt_ymax;
    logic [15:0]   rpt_frame_no;
    logic [2:0]    ctrl_state;

    int checks = 0;
    int errors = 0;
    bit seen_to = 0;

    defect_seq_ctrl #(.COORD_WID(CW), .CONFIRM_FRAMES(CONF), .TOL(TOLP), .TIMEOUT_FRAMES(TMO)) dut (
        .pixclk_in(clk), .rstn_out(rstn), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .frame_vs(frame_vs), .defect_valid(defect_valid),
        .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
        .rpt_ready(rpt_ready), .rpt_valid(rpt_valid),
        .rpt_xmin(rpt_xmin), .rpt_xmax(rpt_xmax), .rpt_ymin(rpt_ymin), .rpt_ymax(rpt_ymax),
        .rpt_frame_no(rpt_frame_no), .det_en(det_en), .ctrl_state(ctrl_state),
        .sess_timeout(sess_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: session phase 0 idle, 1 arm, 2 measure, 3 report, 4 holdoff.
    int m_st = 0, m_frame = 0, m_cnt = 0, m_rfn = 0, m_idle = 0;
    int m_cand[4] = '{0, 0, 0, 0};
    int m_rpt[4]  = '{0, 0, 0, 0};
    bit m_rv = 0, m_to = 0, m_vsd = 0;

    function automatic bit near(input int a, input int b);
        return (a - b <= TOLP) && (b - a <= TOLP);
    endfunction

    task automatic model_step();
        int bb[4];
        bit fe, same;
        bb = '{int'(bb_xmin), int'(bb_xmax), int'(bb_ymin), int'(bb_ymax)};
        fe = frame_vs && !m_vsd;
        m_vsd = frame_vs;
        m_to = 0;
        if (cmd_stop) begin
            m_st = 0; m_rv = 0; m_cnt = 0; m_frame = 0; m_idle = 0;
        end else if (m_st == 0) begin
            if (cmd_start) begin m_st = 1; m_frame = 0; m_cnt = 0; end
        end else if (m_st == 1) begin
            if (fe) begin m_cand = '{0, 0, 0, 0}; m_cnt = 0; m_idle = 0; m_st = 2; end
        end else if (m_st == 2) begin
            if (fe) begin
                m_frame = (m_frame + 1) % 65536;
                same = 1;
                for (int k = 0; k < 4; k++) if (!near(bb[k], m_cand[k])) same = 0;
                if (defect_valid && same) m_cnt = m_cnt + 1;
                else if (defect_valid) begin m_cand = bb; m_cnt = 1; end
                else m_cnt = 0;
                if (defect_valid) m_idle = 0; else m_idle = m_idle + 1;
                if (m_cnt == CONF) begin
                    m_rpt = bb; m_rfn = m_frame; m_rv = 1; m_st = 3;
                end
`ifdef DEFECT_SEQ_TIMEOUT_EN
                else if (m_idle == TMO) begin
                    m_to = 1; m_st = 0; m_cnt = 0; m_idle = 0;
                end
`endif
            end
        end else if (m_st == 3) begin
            if (fe) m_frame = (m_frame + 1) % 65536;
            if (rpt_ready) begin m_rv = 0; m_st = 4; end
        end else begin
            if (fe) begin
                m_frame = (m_frame + 1) % 65536;
                if (!defect_valid) begin m_cnt = 0; m_st = 2; end
            end
        end
    endtask

    function automatic logic [127:0] model_vec();
        return {62'd0, m_rv, 11'(m_rpt[0]), 11'(m_rpt[1]), 11'(m_rpt[2]), 11'(m_rpt[3]),
                16'(m_rfn), (m_st != 0), 3'(m_st), m_to};
    endfunction

    function automatic logic [127:0] dut_vec();
        return {62'd0, rpt_valid, rpt_xmin, rpt_xmax, rpt_ymin, rpt_ymax,
                rpt_frame_no, det_en, ctrl_state, sess_timeout};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (sess_timeout) seen_to = 1;
    endtask

    task automatic frame(input bit dv, input int x0, input int x1, input int y0, input int y1);
        defect_valid = dv;
        bb_xmin = 11'(x0); bb_xmax = 11'(x1); bb_ymin = 11'(y0); bb_ymax = 11'(y1);
        frame_vs = 1'b1;
        tick();
        frame_vs = 1'b0;
        tick();
    endtask

    task automatic start_session();
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        frame(0, 0, 0, 0, 0);
    endtask

    task automatic stop_session();
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    endtask

    typedef struct {
        bit start, stop, vs, dv, ready;
        bit e_rv, e_det;
        logic [2:0] e_st;
        logic [15:0] e_rfn;
        bit e_box;
    } vec_t;

    initial begin
        vec_t tbl[16];
        logic [43:0] box_exp;
        int base[4];
        int per, ph;

        tbl[0]  = '{1,0,0,1,1, 0,1,3'd1,16'd0,0};
        tbl[1]  = '{0,0,0,1,1, 0,1,3'd1,16'd0,0};
        tbl[2]  = '{0,0,1,1,1, 0,1,3'd2,16'd0,0};
        tbl[3]  = '{0,0,0,1,1, 0,1,3'd2,16'd0,0};
        tbl[4]  = '{0,0,1,1,1, 0,1,3'd2,16'd0,0};
        tbl[5]  = '{0,0,0,1,1, 0,1,3'd2,16'd0,0};
        tbl[6]  = '{0,0,1,1,1, 0,1,3'd2,16'd0,0};
        tbl[7]  = '{0,0,0,1,1, 0,1,3'd2,16'd0,0};
        tbl[8]  = '{0,0,1,1,1, 1,1,3'd3,16'd3,1};
        tbl[9]  = '{0,0,0,1,1, 0,1,3'd4,16'd3,1};
        tbl[10] = '{0,0,1,1,1, 0,1,3'd4,16'd3,1};
        tbl[11] = '{0,0,0,1,1, 0,1,3'd4,16'd3,1};
        tbl[12] = '{0,0,1,0,1, 0,1,3'd2,16'd3,1};
        tbl[13] = '{0,1,0,0,1, 0,0,3'd0,16'd3,1};
        tbl[14] = '{1,1,0,0,1, 0,0,3'd0,16'd3,1};
        tbl[15] = '{0,0,0,0,1, 0,0,3'd0,16'd3,1};

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", dut_vec(), 128'd0);
        rstn = 1'b1;

        // Table: start, three identical boxes, back-to-back handshake, holdoff, stop.
        bb_xmin = 11'd10; bb_xmax = 11'd50; bb_ymin = 11'd20; bb_ymax = 11'd60;
        for (int i = 0; i < 16; i++) begin
            cmd_start = tbl[i].start; cmd_stop = tbl[i].stop; frame_vs = tbl[i].vs;
            defect_valid = tbl[i].dv; rpt_ready = tbl[i].ready;
            tick();
            box_exp = tbl[i].e_box ? {11'd10, 11'd50, 11'd20, 11'd60} : 44'd0;
            check("table", dut_vec(),
                  {62'd0, tbl[i].e_rv, box_exp, tbl[i].e_rfn, tbl[i].e_det, tbl[i].e_st, 1'b0});
        end
        cmd_start = 0; cmd_stop = 0; frame_vs = 0; defect_valid = 0; rpt_ready = 0;

        // Jitter exactly TOL still matches; the report carries the last frame's box.
        start_session();
        frame(1, 10, 50, 20, 60);
        frame(1, 14, 50, 20, 60);
        check("tol_mid_state", {rpt_valid, ctrl_state}, {1'b0, 3'd2});
        frame(1, 12, 50, 20, 60);
        check("tol_confirm", {rpt_valid, ctrl_state, rpt_xmin, rpt_frame_no},
              {1'b1, 3'd3, 11'd12, 16'd3});
        rpt_ready = 1; tick(); rpt_ready = 0;
        check("tol_handshake", {rpt_valid, ctrl_state}, {1'b0, 3'd4});
        stop_session();

        // TOL+1 reloads the candidate, so confirmation comes one frame later.
        start_session();
        frame(1, 10, 50, 20, 60);
        frame(1, 15, 50, 20, 60);
        frame(1, 15, 50, 20, 60);
        check("tol1_no_report", {rpt_valid, ctrl_state}, {1'b0, 3'd2});
        frame(1, 15, 50, 20, 60);
        check("tol1_confirm", {rpt_valid, ctrl_state, rpt_xmin, rpt_frame_no},
              {1'b1, 3'd3, 11'd15, 16'd4});
        stop_session();

        // Stalled consumer, holdoff while defect persists, then a second report.
        start_session();
        for (int f = 0; f < 3; f++) frame(1, 30, 40, 70, 80);
        check("stall_confirm", {rpt_valid, ctrl_state, rpt_frame_no}, {1'b1, 3'd3, 16'd3});
        for (int f = 0; f < 5; f++) begin
            frame(1, 500, 600, 700, 800);
            check("stall_hold", {rpt_valid, ctrl_state, rpt_xmin, rpt_xmax, rpt_ymin, rpt_ymax, rpt_frame_no},
                  {1'b1, 3'd3, 11'd30, 11'd40, 11'd70, 11'd80, 16'd3});
        end
        rpt_ready = 1; tick(); rpt_ready = 0;
        check("stall_release", {rpt_valid, ctrl_state}, {1'b0, 3'd4});
        for (int f = 0; f < 4; f++) begin
            frame(1, 30, 40, 70, 80);
            check("holdoff_persist", {rpt_valid, ctrl_state}, {1'b0, 3'd4});
        end
        frame(0, 0, 0, 0, 0);
        check("holdoff_exit", {rpt_valid, ctrl_state}, {1'b0, 3'd2});
        for (int f = 0; f < 3; f++) frame(1, 200, 210, 220, 230);
        check("second_report", {rpt_valid, ctrl_state, rpt_xmin, rpt_xmax, rpt_ymin, rpt_ymax, rpt_frame_no},
              {1'b1, 3'd3, 11'd200, 11'd210, 11'd220, 11'd230, 16'd16});

        // Stop during a stalled report, then start+stop together.
        stop_session();
        check("stop_in_report", {rpt_valid, det_en, ctrl_state}, {1'b0, 1'b0, 3'd0});
        cmd_start = 1; cmd_stop = 1; tick(); cmd_start = 0; cmd_stop = 0;
        check("start_stop_same", {det_en, ctrl_state}, {1'b0, 3'd0});
        tick();
        check("start_stop_after", {det_en, ctrl_state}, {1'b0, 3'd0});

        // A frame edge coinciding with stop must not confirm.
        start_session();
        frame(1, 5, 6, 7, 8);
        frame(1, 5, 6, 7, 8);
        frame_vs = 1; cmd_stop = 1; tick(); frame_vs = 0; cmd_stop = 0;
        check("stop_with_fedge", {rpt_valid, det_en, ctrl_state}, {1'b0, 1'b0, 3'd0});
        tick();
        check("stop_with_fedge_after", {rpt_valid, det_en, ctrl_state}, {1'b0, 1'b0, 3'd0});

`ifdef DEFECT_SEQ_TIMEOUT_EN
        seen_to = 0;
        start_session();
        for (int f = 0; f < TMO - 1; f++) frame(0, 0, 0, 0, 0);
        check("pre_timeout", {seen_to, ctrl_state}, {1'b0, 3'd2});
        defect_valid = 0; frame_vs = 1; tick(); frame_vs = 0;
        check("timeout_pulse", {sess_timeout, det_en, ctrl_state}, {1'b1, 1'b0, 3'd0});
        tick();
        check("timeout_pulse_end", {sess_timeout, ctrl_state}, {1'b0, 3'd0});
        seen_to = 0;
        start_session();
        for (int f = 0; f < TMO - 1; f++) frame(0, 0, 0, 0, 0);
        frame(1, 900, 901, 902, 903);
        for (int f = 0; f < TMO - 1; f++) frame(0, 0, 0, 0, 0);
        check("no_timeout", {seen_to, ctrl_state}, {1'b0, 3'd2});
`else
        seen_to = 0;
        start_session();
        for (int f = 0; f < TMO + 5; f++) frame(0, 0, 0, 0, 0);
        check("no_timeout_feature", {seen_to, det_en, ctrl_state}, {1'b0, 1'b1, 3'd2});
`endif
        stop_session();

        // Randomized traffic against the model.
        base = '{100, 200, 50, 150};
        per = 7; ph = 0;
        for (int i = 0; i < 3000; i++) begin
            cmd_start = ($urandom_range(0, 19) == 0);
            cmd_stop  = ($urandom_range(0, 249) == 0);
            frame_vs  = (ph < 2);
            ph++;
            if (ph >= per) begin ph = 0; per = $urandom_range(4, 9); end
            defect_valid = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 15) == 0)
                for (int k = 0; k < 4; k++) base[k] = $urandom_range(0, 2040);
            bb_xmin = 11'(base[0] + $urandom_range(0, 6));
            bb_xmax = 11'(base[1] + $urandom_range(0, 6));
            bb_ymin = 11'(base[2] + $urandom_range(0, 6));
            bb_ymax = 11'(base[3] + $urandom_range(0, 6));
            rpt_ready = $urandom_range(0, 1);
            tick();
            check("random", dut_vec(), model_vec());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/defect_seq_ctrl.md
# defect_seq_ctrl

Session controller for the binary-image defect detector. It arms the detector on command and samples the per-frame defect bounding box at each frame boundary. It confirms a defect only after it stays stable across several consecutive frames, then hands one report to a downstream consumer (UART/overlay) over a valid/ready handshake. It sits between the detector's result outputs and the reporting logic, and gates the detector with `det_en`.

## Interface
Parameters:
- `COORD_WID`, 11, coordinate width; must match the detector.
- `CONFIRM_FRAMES`, 3, consecutive matching frames needed to confirm (1..15).
- `TOL`, 4, per-edge jitter tolerance in pixels.
- `TIMEOUT_FRAMES`, 15, consecutive defect-free frames before the session ends (only with the macro; 1..255).

Ports:
- `pixclk_in`  in  1  pixel clock.
- `rstn_out`  in  1  reset, asynchronous, active-low.
- `cmd_start`  in  1  one-cycle pulse; starts a session.
- `cmd_stop`  in  1  one-cycle pulse; aborts the session.
- `frame_vs`  in  1  delayed frame sync from the detector (`point_vs`).
- `defect_valid`  in  1  detector reports a defect in the last frame.
- `bb_xmin`, `bb_xmax`, `bb_ymin`, `bb_ymax`  in  COORD_WID each  detector bounding box.
- `rpt_ready`  in  1  consumer accepts the report.
- `rpt_valid`  out  1  report available.
- `rpt_xmin`, `rpt_xmax`, `rpt_ymin`, `rpt_ymax`  out  COORD_WID each  confirmed box.
- `rpt_frame_no`  out  16  session frame number at confirmation.
- `det_en`  out  1  detector enable; high whenever state ≠ IDLE.
- `ctrl_state`  out  3  current state encoding.
- `sess_timeout`  out  1  one-cycle pulse when a session times out.

## Operation
- Frame edge: `vs_d <= frame_vs`; `fedge = frame_vs & ~vs_d`. All per-frame actions happen in the cycle where `fedge=1`.
- States:
  - IDLE=0: `cmd_start` → ARM.
  - ARM=1: the first `fedge` only aligns to the frame. Clear the candidate and `match_cnt`, go to MEASURE. The frame counter does not increment.
  - MEASURE=2: on `fedge`, increment `frame_no`.
    - If `defect_valid` and all four edges are within TOL of the candidate: `match_cnt++`.
    - Else if `defect_valid`: load the candidate from `bb_*`, set `match_cnt=1`.
    - Else: set `match_cnt=0`.
    - When the updated `match_cnt` equals CONFIRM_FRAMES: latch `rpt_*` from `bb_*`, latch `rpt_frame_no=frame_no` (post-increment value), go to REPORT.
  - REPORT=3: hold `rpt_valid=1` and stable `rpt_*` until `rpt_valid&rpt_ready`, then go to HOLDOFF. Frame edges still increment `frame_no` but are otherwise ignored.
  - HOLDOFF=4: on `fedge` increment `frame_no`. The first frame with `defect_valid=0` sets `match_cnt=0` and goes to MEASURE. This gives one report per defect occurrence.
- `cmd_stop` in any state: go to IDLE next cycle, drop `rpt_valid` without a handshake, clear the counters. If `cmd_stop` and `cmd_start` are both asserted, stop wins. `cmd_start` outside IDLE is ignored.
- Tolerance check: `|a-b|` is computed at COORD_WID+1 bits signed, and the check passes when it is ≤ TOL.
- `frame_no`: 16-bit, wraps 0xFFFF→0. It is cleared on entry to ARM.
- `match_cnt`: 4-bit; saturation is never reached because MEASURE exits at CONFIRM_FRAMES.

## Timing
- Reset values: all outputs 0, state IDLE, `vs_d=0`, counters 0.
- All outputs are registered.
- `det_en` rises 1 cycle after `cmd_start` and falls 1 cycle after `cmd_stop`.
- `rpt_valid` rises 1 cycle after the confirming `fedge`. It falls the cycle after the handshake.
- Back-to-back: `rpt_ready` held high gives a 1-cycle `rpt_valid` pulse.
- An `fedge` in the same cycle as `cmd_stop` is discarded.
- Minimum confirm latency from ARM exit: CONFIRM_FRAMES frame edges.

## Configuration
- `DEFECT_SEQ_TIMEOUT_EN` defined:
  - An 8-bit `idle_frames` counter increments on each defect-free `fedge` in MEASURE and is cleared by any `defect_valid` frame.
  - When it reaches TIMEOUT_FRAMES: pulse `sess_timeout` for 1 cycle and go to IDLE.
- Undefined:
  - No counter; `sess_timeout` is tied to 0.
  - MEASURE continues indefinitely.

## Test plan
- Start; 3 frames with identical box (10,50,20,60) and `rpt_ready=1` → `rpt_valid` for 1 cycle, `rpt_*` = (10,50,20,60), `rpt_frame_no=3`.
- Boxes differing by TOL (xmin 10,14,12) → confirm on frame 3. Difference of TOL+1 → candidate reload, `match_cnt=1`, no report until 3 further matches.
- Hold `rpt_ready=0` for 5 frames → `rpt_valid` and the data are stable, state stays REPORT. Then `ready=1` → HOLDOFF. The defect persists for 4 frames → no second report. A clean frame followed by 3 defect frames → second report.
- `cmd_stop` during REPORT with `ready=0` → `rpt_valid=0` and `det_en=0` next cycle, state IDLE. `cmd_start` and `cmd_stop` in the same cycle → stays IDLE.
- With `DEFECT_SEQ_TIMEOUT_EN`: 15 clean frames → `sess_timeout` pulse and IDLE. 14 clean frames, 1 defect frame, 14 clean frames → no timeout.
